decoder_nx2n_scan: RTL and testbench

DECODER_NX2N_SCAN -- requirements
Module: decoder_nx2n_scan

---
 rtl/decoder_pkg.sv | 20 ++
 rtl/decoder_scan_ctr.sv | 52 +++++
 rtl/decoder_nx2n_scan.sv | 121 ++++++++++++
 tb/tb_decoder_nx2n_scan.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and limits for the N-to-2**N decoder with optional scan mode.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int N_MIN     = 1;
  localparam int N_MAX     = 6;
  localparam int DWELL_MIN = 1;
  localparam int DWELL_MAX = 255;

  localparam int DWELL_W = $clog2(DWELL_MAX + 1);

endpackage

// File: rtl/decoder_scan_ctr.sv
// Scan index and dwell counters; exposes the index the output will show next cycle.
module decoder_scan_ctr
  import decoder_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = 4
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_step,
  output logic [N-1:0] o_idx_nxt
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  logic [N-1:0]       r_idx;
  logic [N-1:0]       w_idx_nxt;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_nxt;

  // Index is exactly N bits, so 2**N-1 + 1 wraps to 0 on its own.
  always_comb begin
    w_idx_nxt   = r_idx;
    w_dwell_nxt = r_dwell;
    if (i_load) begin
      w_idx_nxt   = '0;
      w_dwell_nxt = '0;
    end else if (i_step) begin
      if (r_dwell == DWELL_LAST) begin
        w_dwell_nxt = '0;
        w_idx_nxt   = r_idx + 1'b1;
      end else begin
        w_dwell_nxt = r_dwell + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_dwell <= '0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_dwell <= w_dwell_nxt;
    end
  end

  assign o_idx_nxt = w_idx_nxt;

endmodule

// File: rtl/decoder_nx2n_scan.sv
// Registered N-to-2**N one-hot decoder with valid/ready handshake.
// Scan mode (cycling through all codes) is built only with DECODER_SCAN_EN.
module decoder_nx2n_scan
  import decoder_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = 4
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [N-1:0]     w,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [0:2**N-1]  y,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int W = 2**N;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [0:W-1]   r_y;
  logic [0:W-1]   w_y_nxt;
  logic           w_mode;
  logic           w_xfer;
  logic [N-1:0]   w_scan_idx_nxt;

  function automatic logic [0:W-1] onehot(input logic [N-1:0] v);
    logic [0:W-1] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

`ifdef DECODER_SCAN_EN
  logic w_scan_load;
  logic w_scan_step;

  assign w_mode      = mode;
  assign w_scan_load = (r_state == IDLE) && (w_state_nxt == SCAN);
  assign w_scan_step = (r_state == SCAN) && out_ready;

  decoder_scan_ctr #(
    .N     (N),
    .DWELL (DWELL)
  ) u_scan_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_scan_load),
    .i_step    (w_scan_step),
    .o_idx_nxt (w_scan_idx_nxt)
  );
`else
  logic w_mode_unused;

  assign w_mode         = MODE_DIRECT;
  assign w_mode_unused  = mode;
  assign w_scan_idx_nxt = '0;
`endif

  // Gated by rst_n so the handshake is closed while reset is held.
  assign in_ready = rst_n & en & (w_mode == MODE_DIRECT) &
                    ((r_state == IDLE) | ((r_state == HOLD) & out_ready));
  assign w_xfer   = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_state_nxt = HOLD;
          w_y_nxt     = onehot(w);
        end else if (en && (w_mode == MODE_SCAN)) begin
          w_state_nxt = SCAN;
          w_y_nxt     = onehot('0);
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (w_xfer) begin
            w_y_nxt = onehot(w);
          end else begin
            w_state_nxt = IDLE;
            w_y_nxt     = '0;
          end
        end
      end
      SCAN: begin
        if (!en || (w_mode == MODE_DIRECT)) begin
          w_state_nxt = IDLE;
          w_y_nxt     = '0;
        end else begin
          w_y_nxt = onehot(w_scan_idx_nxt);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_y_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
    end
  end

  assign y         = r_y;
  assign out_valid = (r_state == HOLD) || (r_state == SCAN);

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Scoreboard bench: driver predicts consumed codes from a behavioural model, a monitor pops them.
module tb_decoder_nx2n_scan;

  localparam int N     = 2;
  localparam int DWELL = 2;
  localparam int W     = 2**N;

`ifdef DECODER_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  typedef logic [0:W-1] code_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         mode;
  logic [N-1:0] w;
  logic         in_valid;
  logic         in_ready;
  code_t        y;
  logic         out_valid;
  logic         out_ready;

  always #5 clk = ~clk;

  decoder_nx2n_scan #(
    .N     (N),
    .DWELL (DWELL)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .w         (w),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  code_t       sb[$];

  // Reference model: busy-with-held-code, scanning, and number of scan slots consumed.
  bit          m_hold = 1'b0;
  bit          m_scan = 1'b0;
  int unsigned m_pos  = 0;

  function automatic code_t code_of(input int unsigned v);
    code_t c;
    c = '0;
    for (int unsigned i = 0; i < W; i++)
      if (i == v) c[i] = 1'b1;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    code_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected got=%b want=none at %0t", y, $time);
      end else begin
        e = sb.pop_front();
        chk("sb_y", 32'(y), 32'(e));
      end
    end
  end

  // Called at posedge+1; applies inputs, predicts the coming edge, then returns at next posedge+1.
  task automatic drive(input logic ien, input logic imode, input logic ivld,
                       input int unsigned iw, input logic ordy);
    bit eff, rdy, xfer;
    en        = ien;
    mode      = imode;
    in_valid  = ivld;
    w         = N'(iw);
    out_ready = ordy;
    #1;
    eff  = SCAN_ON && imode;
    rdy  = ien && !eff && ((!m_hold && !m_scan) || (m_hold && ordy));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    xfer = ivld && rdy;
    if (m_hold) begin
      if (ordy) begin
        if (xfer) sb.push_back(code_of(iw % W));
        else m_hold = 1'b0;
      end
    end else if (m_scan) begin
      if (ordy) begin
        sb.push_back(code_of((m_pos / DWELL) % W));
        m_pos++;
      end
      if (!ien || !eff) m_scan = 1'b0;
    end else if (xfer) begin
      m_hold = 1'b1;
      sb.push_back(code_of(iw % W));
    end else if (ien && eff) begin
      m_scan = 1'b1;
      m_pos  = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_hold || m_scan));
    if (!(m_hold || m_scan)) chk("idle_y", 32'(y), 32'(0));
  endtask

  task automatic mid_reset();
    #6;
    en       = 1'b1;
    mode     = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_y", 32'(y), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    sb.delete();
    m_hold = 1'b0;
    m_scan = 1'b0;
    m_pos  = 0;
    en     = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    w         = '0;
    out_ready = 1'b1;
    #2;
    chk("por_y", 32'(y), 32'(0));
    chk("por_out_valid", 32'(out_valid), 32'(0));
    chk("por_in_ready", 32'(in_ready), 32'(0));
    #1;
    rst_n = 1'b1;

    // Back-to-back direct codes, first one on the first edge after reset.
    for (int unsigned i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, i, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 0, 1'b1);

    // Held code under backpressure with noisy en/mode/w.
    drive(1'b1, 1'b0, 1'b1, 2, 1'b1);
    for (int i = 0; i < 5; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, W - 1), 1'b0);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 0, 1'b1);

    // Scan with wrap, stall, reset mid-scan, restart.
    repeat (10) drive(1'b1, 1'b1, 1'b0, 0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 0, 1'b1);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
    repeat (6) drive(1'b1, 1'b1, 1'b0, 0, 1'b1);
    mid_reset();
    repeat (4) drive(1'b1, 1'b1, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);

    // mode=1 with a valid w=3: direct decode when scan is not built.
    drive(1'b1, 1'b1, 1'b1, 3, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), $urandom_range(0, W - 1),
            1'($urandom_range(0, 3) != 0));
    end

    repeat (6) drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
